// File: rtl/display_pkg.sv
// Shared constants and helpers for the 3-digit scan driver: segment patterns,
// digit/flag counts and the slot enumeration used by the scan sequencer.
package display_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int NUM_FLAGS  = 2 * NUM_DIGITS;
  localparam int NUM_PULSES = 2 * NUM_FLAGS;

  // Segment order is gfedcba, active-low: a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2
  } slot_t;

  function automatic logic [6:0] seg_lut(input logic [1:0] code);
    logic [6:0] pattern;
    case (code)
      2'b00:   pattern = SEG_0;
      2'b01:   pattern = SEG_1;
      2'b10:   pattern = SEG_2;
      default: pattern = SEG_3;
    endcase
    return pattern;
  endfunction

  function automatic slot_t next_slot(input slot_t cur);
    slot_t nxt;
    case (cur)
      SLOT_0:  nxt = SLOT_1;
      SLOT_1:  nxt = SLOT_2;
      default: nxt = SLOT_0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Pulse bus from the digit decoder plus the display pin group driven by the
// scan driver; the decoder side is the master, the driver is the slave.
interface display_scan_driver_if;
  import display_pkg::*;

  logic [NUM_PULSES-1:0] sr_pulse;
  logic [NUM_FLAGS-1:0]  flags;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_done;
  logic                  conflict;

  modport master (
    output sr_pulse,
    input  flags,
    input  seg,
    input  an,
    input  frame_done,
    input  conflict
  );

  modport slave (
    input  sr_pulse,
    output flags,
    output seg,
    output an,
    output frame_done,
    output conflict
  );

endinterface

// File: rtl/display_scan_driver_sr_flag_bank.sv
// Six set/reset flag cells fed by paired pulses; reset dominates, and a
// simultaneous set+reset on any cell latches a sticky conflict flag.
module sr_flag_bank
  import display_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PULSES-1:0] sr_pulse,
  output logic [NUM_FLAGS-1:0]  flags,
  output logic                  conflict
);

  logic [NUM_FLAGS-1:0] set_vec;
  logic [NUM_FLAGS-1:0] clr_vec;
  logic [NUM_FLAGS-1:0] flags_next;
  logic                 clash;

  // Pulse bit 2k sets flag k, bit 2k+1 clears it.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int k = 0; k < NUM_FLAGS; k++) begin
      set_vec[k] = sr_pulse[2*k];
      clr_vec[k] = sr_pulse[2*k+1];
    end
  end

  assign flags_next = (flags | set_vec) & ~clr_vec;
  assign clash      = |(set_vec & clr_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= '0;
      conflict <= 1'b0;
    end else begin
      flags <= flags_next;
      if (clash) begin
        conflict <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Latches decoder flags and time-multiplexes three 2-bit codes onto a
// common-anode 7-segment display with a blank gap at the start of each slot.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_driver_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  slot_t                 slot;
  slot_t                 slot_next;
  logic [NUM_FLAGS-1:0]  flags;
  logic [NUM_FLAGS-1:0]  shadow;
  logic                  conflict;
  logic                  tick;
  logic                  frame_tick;
  logic                  in_dead;
  logic [1:0]            code;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;

  sr_flag_bank u_flag_bank (
    .clk      (clk),
    .rst      (rst),
    .sr_pulse (bus.sr_pulse),
    .flags    (flags),
    .conflict (conflict)
  );

  assign bus.flags    = flags;
  assign bus.conflict = conflict;

  assign tick       = (count == CW'(PRESCALE - 1));
  assign frame_tick = tick && (slot == SLOT_2);
  assign in_dead    = (count < CW'(DEAD));

  always_comb begin
    count_next = count + CW'(1);
    slot_next  = slot;
    if (tick) begin
      count_next = '0;
      slot_next  = next_slot(slot);
    end
  end

  // Shadow only moves on the frame boundary so a frame never mixes codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      slot   <= SLOT_0;
      shadow <= '0;
    end else begin
      count <= count_next;
      slot  <= slot_next;
      if (frame_tick) begin
        shadow <= flags;
      end
    end
  end

  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    code     = 2'b00;
    case (slot)
      SLOT_0:  code = shadow[1:0];
      SLOT_1:  code = shadow[3:2];
      SLOT_2:  code = shadow[5:4];
      default: code = 2'b00;
    endcase
    if (!in_dead) begin
      seg_next = seg_lut(code);
      case (slot)
        SLOT_0:  an_next = 3'b110;
        SLOT_1:  an_next = 3'b101;
        SLOT_2:  an_next = 3'b011;
        default: an_next = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg        <= SEG_BLANK;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_next;
      bus.an         <= an_next;
      bus.frame_done <= frame_tick;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: a cycle-numbered reference model checks every
// output each cycle, plus a flag vector table and directed frame sequences.
module tb_display_scan_driver;

  localparam int PRESCALE = 4;
  localparam int DEAD     = 1;
  localparam int FRAME    = 3 * PRESCALE;

  typedef struct {
    logic [11:0] pulse;
    logic [5:0]  exp_flags;
    logic        exp_conflict;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  bit         m_valid = 1'b0;
  int         cyc     = 0;
  logic [5:0] m_flags;
  logic [5:0] m_shadow;
  logic       m_conflict;
  logic [2:0] e_an;
  logic [6:0] e_seg;
  logic       e_fd;

  logic [6:0] cap_seg [3];
  int         cap_low [3];
  int         fd_cyc;
  vec_t       tbl [11];

  display_scan_driver_if bus ();

  display_scan_driver #(
    .PRESCALE (PRESCALE),
    .DEAD     (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [1:0] code);
    logic [6:0] digits [4];
    digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    return digits[code];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    if (m_valid) begin
      chk("flags", 32'(bus.flags), 32'(m_flags));
      chk("seg", 32'(bus.seg), 32'(e_seg));
      chk("an", 32'(bus.an), 32'(e_an));
      chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
      chk("conflict", 32'(bus.conflict), 32'(m_conflict));
      chk("an_single_low", 32'($countones(~bus.an) <= 1), 32'(1));
    end
  endtask

  // Model indexes time by cycle number since the last reset edge (cycle 1 is
  // the first cycle out of reset) and derives slot position arithmetically.
  task automatic applyStimulus(input logic [11:0] p, input logic r);
    int         pos;
    int         dig;
    logic [5:0] nxt;
    bus.sr_pulse = p;
    rst          = r;
    if (r) begin
      m_valid    = 1'b1;
      cyc        = 1;
      m_flags    = '0;
      m_shadow   = '0;
      m_conflict = 1'b0;
      e_an       = 3'b111;
      e_seg      = 7'h7F;
      e_fd       = 1'b0;
    end else if (m_valid) begin
      pos = (cyc - 1) % PRESCALE;
      dig = ((cyc - 1) / PRESCALE) % 3;
      if (pos < DEAD) begin
        e_an  = 3'b111;
        e_seg = 7'h7F;
      end else begin
        e_an  = ~(3'b001 << dig);
        e_seg = ref_seg(m_shadow[2*dig +: 2]);
      end
      e_fd = ((cyc % FRAME) == 0);
      if (e_fd) m_shadow = m_flags;
      nxt = m_flags;
      for (int k = 0; k < 6; k++) begin
        if (p[2*k+1]) nxt[k] = 1'b0;
        else if (p[2*k]) nxt[k] = 1'b1;
        if (p[2*k] && p[2*k+1]) m_conflict = 1'b1;
      end
      m_flags = nxt;
      cyc++;
    end
  endtask

  task automatic step(input logic [11:0] p, input logic r);
    applyStimulus(p, r);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    repeat (3) step(12'($urandom), 1'b1);
  endtask

  task automatic captureFrame(input string tag);
    bit done;
    int guard;
    done   = 1'b0;
    guard  = 0;
    fd_cyc = -1;
    for (int d = 0; d < 3; d++) begin
      cap_seg[d] = 7'h7F;
      cap_low[d] = 0;
    end
    while (!done && guard < 40) begin
      step(12'h000, 1'b0);
      guard++;
      for (int d = 0; d < 3; d++) begin
        if (bus.an == ~(3'b001 << d)) begin
          cap_seg[d] = bus.seg;
          cap_low[d]++;
        end
      end
      if (bus.frame_done) begin
        done   = 1'b1;
        fd_cyc = cyc;
      end
    end
    chk({tag, "_frame_seen"}, 32'(done), 32'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] p;
    logic        r;

    bus.sr_pulse = '0;
    tbl[0]  = '{12'h000, 6'b000000, 1'b0};
    tbl[1]  = '{12'h015, 6'b000111, 1'b0};
    tbl[2]  = '{12'h008, 6'b000101, 1'b0};
    tbl[3]  = '{12'h0A0, 6'b000001, 1'b0};
    tbl[4]  = '{12'h500, 6'b110001, 1'b0};
    tbl[5]  = '{12'h004, 6'b110011, 1'b0};
    tbl[6]  = '{12'h00C, 6'b110001, 1'b1};
    tbl[7]  = '{12'h000, 6'b110001, 1'b1};
    tbl[8]  = '{12'hFFF, 6'b000000, 1'b1};
    tbl[9]  = '{12'h555, 6'b111111, 1'b1};
    tbl[10] = '{12'hAAA, 6'b000000, 1'b1};

    @(negedge clk);
    doReset();
    chk("rst_flags", 32'(bus.flags), 32'(0));
    chk("rst_an", 32'(bus.an), 32'(3'b111));
    chk("rst_seg", 32'(bus.seg), 32'(7'h7F));
    chk("rst_conflict", 32'(bus.conflict), 32'(0));

    // Flags 0 set, 1 cleared, 2 set; first frame still shows the zero shadow.
    step(12'h019, 1'b0);
    chk("set_flags", 32'(bus.flags), 32'(6'b000101));
    captureFrame("first");
    chk("frame_done_cycle", 32'(fd_cyc), 32'(13));
    for (int d = 0; d < 3; d++) begin
      chk("first_seg", 32'(cap_seg[d]), 32'(7'b1000000));
      chk("first_low_len", 32'(cap_low[d]), 32'(3));
    end
    captureFrame("second");
    chk("set_seg0", 32'(cap_seg[0]), 32'(7'b1111001));
    chk("set_seg1", 32'(cap_seg[1]), 32'(7'b1111001));
    chk("set_seg2", 32'(cap_seg[2]), 32'(7'b1000000));
    for (int d = 0; d < 3; d++) chk("second_low_len", 32'(cap_low[d]), 32'(3));

    doReset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].pulse, 1'b0);
      chk("tbl_flags", 32'(bus.flags), 32'(tbl[i].exp_flags));
      chk("tbl_conflict", 32'(bus.conflict), 32'(tbl[i].exp_conflict));
    end
    repeat (5) step(12'h000, 1'b0);
    chk("conflict_sticky", 32'(bus.conflict), 32'(1));
    doReset();
    chk("conflict_cleared", 32'(bus.conflict), 32'(0));

    // Frame coherence: load A=011011, then switch to B=100100 during slot 1.
    step(12'h145, 1'b0);
    chk("coh_flags_a", 32'(bus.flags), 32'(6'b011011));
    captureFrame("coh_load");
    for (int g = 0; g < 20 && cyc < 18; g++) step(12'h000, 1'b0);
    chk("coh_at_slot1", 32'(cyc), 32'(18));
    step(12'h69A, 1'b0);
    chk("coh_flags_b", 32'(bus.flags), 32'(6'b100100));
    captureFrame("coh_old");
    chk("coh_old_seg1", 32'(cap_seg[1]), 32'(7'b0100100));
    chk("coh_old_seg2", 32'(cap_seg[2]), 32'(7'b1111001));
    captureFrame("coh_new");
    chk("coh_new_seg0", 32'(cap_seg[0]), 32'(7'b1000000));
    chk("coh_new_seg1", 32'(cap_seg[1]), 32'(7'b1111001));
    chk("coh_new_seg2", 32'(cap_seg[2]), 32'(7'b0100100));

    doReset();
    step(12'h500, 1'b0);
    captureFrame("d3_first");
    captureFrame("d3_second");
    chk("digit3_seg2", 32'(cap_seg[2]), 32'(7'b0110000));
    chk("digit3_seg0", 32'(cap_seg[0]), 32'(7'b1000000));

    // Sparse random pulses with occasional mid-frame resets.
    for (int i = 0; i < 600; i++) begin
      p = 12'($urandom & $urandom & $urandom);
      r = ($urandom_range(0, 149) == 0);
      step(p, r);
    end
    step(12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Receiving end of the gated set/reset pulse bus produced by the irrigation digit decoder.
- Latches the six SR flag pairs into state bits and groups them into three 2-bit digit codes.
- Time-multiplexes the codes onto a 3-digit common-anode 7-segment display, with blanking between digits.
- Sits between the decoder and the board display pins; one instance per display.

Parameters:
- PRESCALE, 50000, clock cycles per digit slot; legal range 4..2^20.
- DEAD, 2, blanking cycles at the start of each slot; must be < PRESCALE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous to clk, active-high.
- sr_pulse  in  12  set/reset pulses. Bit 2k = set of flag k, bit 2k+1 = reset of flag k, k=0..5. Each pulse is one or more cycles high.
- flags  out  6  latched flag state, registered.
- seg  out  7  segments gfedcba, active-low, registered.
- an  out  3  digit anodes, active-low, an[0] = rightmost digit, registered.
- frame_done  out  1  one-cycle pulse at the start of each scan frame.
- conflict  out  1  sticky: set and reset of the same flag were seen in the same cycle.

Behaviour:
- Reset: while rst=1 at a clk edge, all of the following are cleared:
  - flags=0, shadow=0, prescale counter=0, slot index=0.
  - seg=7'h7F, an=3'b111, frame_done=0, conflict=0.
- Reset is honoured mid-frame and mid-pulse; there is no partial state.
- Flag k, per cycle:
  - reset pulse high -> 0.
  - else set pulse high -> 1.
  - else hold.
  - Reset wins on simultaneous set and reset; that cycle also sets conflict, which is cleared only by rst.
  - flags reflects a pulse 1 cycle after the pulse is sampled.
- Digit codes: digit d uses flags[2d+1:2d], d=0..2.
- Shadow register:
  - Captures all flags on the frame-start tick, so one frame never mixes old and new values.
  - Before the first frame-start, shadow is 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and then wraps.
  - A tick occurs when the count equals PRESCALE-1.
- Slot index:
  - Advances 0->1->2->0 on each tick.
  - The tick taking index 2->0 is the frame-start tick: the shadow loads and frame_done=1 in the following cycle.
  - The first frame-start occurs after 3*PRESCALE cycles out of reset.
- Within a slot, with c = prescale count:
  - c < DEAD: an=111, seg=7F.
  - c >= DEAD: an has only bit[index] low, and seg = LUT(shadow code of digit index).
  - Outputs are registered: 1 cycle after the internal count/index.
- Segment LUT (gfedcba, active-low):
  - 00 -> 7'b1000000 ("0").
  - 01 -> 7'b1111001 ("1").
  - 10 -> 7'b0100100 ("2").
  - 11 -> 7'b0110000 ("3").
- Invariants:
  - At most one an bit is low in any cycle.
  - an is never low while seg is being switched: a digit change always passes through ≥DEAD blank cycles.
- Widths: the prescale counter is $clog2(PRESCALE) bits; the index is 2 bits and never takes the value 3.

Decomposition:
- Shared package display_pkg holds:
  - segment constants SEG_BLANK and SEG_0..SEG_3;
  - function seg_lut(2-bit code);
  - NUM_DIGITS=3.
- Sub-module sr_flag_bank holds:
  - the 6 SR cells;
  - the reset-wins priority;
  - the conflict detection.
- The top level holds the prescaler, index, shadow and output registers.

Test Plan:
- Bench uses PRESCALE=4, DEAD=1.
- Reset: hold rst 3 cycles with random sr_pulse -> flags=0, an=111, seg=7F, conflict=0 throughout and one cycle after release.
- Set flags: pulse bits 0, 3, 4 for 1 cycle -> flags=6'b000101 next cycle. After the next frame-start:
  - an[0] slot shows seg=7'b1111001;
  - an[1] slot shows 7'b1111001;
  - an[2] slot shows 7'b1000000.
- Reset priority: bits 2 and 3 high together with flag1=1 -> flag1=0 next cycle, conflict=1 and it stays 1 until rst.
- Frame coherence: change flags mid-frame (index=1) -> the current frame still shows the old codes; the new codes appear after frame_done.
- Scan timing: count cycles from rst release:
  - frame_done at cycle 13;
  - each an low for exactly 3 consecutive cycles, preceded by 1 blank cycle;
  - never two an bits low at once.
- Digit 3 pattern: set flags 4 and 5 -> the an[2] slot shows 7'b0110000 after the next frame-start.
